// File: rtl/j11bus_pkg.sv
// Shared types for the J11 bus responder: FSM states, decoded regions, the latched
// request record and the address decoder.
package j11bus_pkg;

  localparam logic [21:0] DEF_IOBASE = 22'o17760000;
  localparam logic [21:0] DEF_MEMTOP = 22'o17760000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_DEV    = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  typedef enum logic [1:0] {REG_MEM, REG_DEV, REG_NXM, REG_LOCAL} region_t;

  typedef struct packed {
    logic        wr;
    logic        gp;
    logic        irq;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [1:0]  bs;
  } bus_req_t;

  // Local cycles (IACK, GP) take priority over any address decode.
  function automatic region_t decode_region(input logic [21:0] addr, input logic gp,
                                            input logic irq, input logic [21:0] memtop,
                                            input logic [21:0] iobase);
    if (irq || gp)          return REG_LOCAL;
    else if (addr < memtop) return REG_MEM;
    else if (addr >= iobase) return REG_DEV;
    else                    return REG_NXM;
  endfunction

endpackage

// File: rtl/j11bus_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module j11bus_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/j11bus_target.sv
// J11 internal bus responder: latches a request, routes it to memory, I/O page or
// local handling, and returns one busack pulse with busrdata/buserr.
module j11bus_target
  import j11bus_pkg::*;
#(
  parameter logic [21:0] MEMTOP  = DEF_MEMTOP,
  parameter logic [21:0] IOBASE  = DEF_IOBASE,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busreq,
  input  logic        buswr,
  input  logic        busgp,
  input  logic        busirq,
  input  logic [21:0] busaddr,
  input  logic [15:0] buswdata,
  input  logic [1:0]  buswstrb,
  input  logic [1:0]  busbs,
  output logic        busack,
  output logic [15:0] busrdata,
  output logic        buserr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [20:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        dev_req,
  output logic        dev_wr,
  output logic [12:0] dev_addr,
  output logic [15:0] dev_wdata,
  output logic [1:0]  dev_wstrb,
  output logic [1:0]  dev_bs,
  input  logic        dev_ack,
  input  logic        dev_err,
  input  logic [15:0] dev_rdata,
  input  logic [8:0]  irq_vec,
  input  logic        irq_vld,
  output logic        irq_take,
  output logic        protoerr
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t   state;
  bus_req_t req_q;
  region_t  region;
  logic     tmr_expired;

  assign region = decode_region(req_q.addr, req_q.gp, req_q.irq, MEMTOP, IOBASE);

  // Loaded while decoding so the count is TIMEOUT-1 on the first MEM/DEV cycle.
  j11bus_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_DECODE),
    .load_val (TW'(TIMEOUT - 1)),
    .expired  (tmr_expired)
  );

  assign mem_wr    = req_q.wr;
  assign mem_addr  = req_q.addr[21:1];
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wr ? req_q.wstrb : 2'b11;
  assign dev_wr    = req_q.wr;
  assign dev_addr  = req_q.addr[12:0];
  assign dev_wdata = req_q.wdata;
  assign dev_wstrb = req_q.wr ? req_q.wstrb : 2'b11;
  assign dev_bs    = req_q.bs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_q    <= '0;
      busack   <= 1'b0;
      buserr   <= 1'b0;
      busrdata <= '0;
      mem_req  <= 1'b0;
      dev_req  <= 1'b0;
      irq_take <= 1'b0;
      protoerr <= 1'b0;
    end else begin
      busack   <= 1'b0;
      buserr   <= 1'b0;
      irq_take <= 1'b0;
      if (busreq && state != S_IDLE) protoerr <= 1'b1;
      case (state)
        S_IDLE: if (busreq) begin
          req_q <= '{wr: buswr, gp: busgp, irq: busirq, addr: busaddr,
                     wdata: buswdata, wstrb: buswstrb, bs: busbs};
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (region)
            REG_MEM: begin state <= S_MEM; mem_req <= 1'b1; end
            REG_DEV: begin state <= S_DEV; dev_req <= 1'b1; end
            REG_LOCAL: begin
              state    <= S_ACK;
              busack   <= 1'b1;
              busrdata <= req_q.irq ? {7'b0, irq_vec} : 16'h0;
              buserr   <= req_q.irq && !irq_vld;
              irq_take <= req_q.irq && irq_vld;
            end
            default: begin
              state    <= S_ACK;
              busack   <= 1'b1;
              buserr   <= 1'b1;
              busrdata <= '0;
            end
          endcase
        end
        S_MEM: if (mem_ack || tmr_expired) begin
          mem_req  <= 1'b0;
          state    <= S_ACK;
          busack   <= 1'b1;
          buserr   <= !mem_ack;
          busrdata <= (mem_ack && !req_q.wr) ? mem_rdata : 16'h0;
        end
        S_DEV: if (dev_ack || tmr_expired) begin
          dev_req  <= 1'b0;
          state    <= S_ACK;
          busack   <= 1'b1;
          buserr   <= dev_ack ? dev_err : 1'b1;
          busrdata <= (dev_ack && !req_q.wr) ? dev_rdata : 16'h0;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_j11bus_target.sv
// Scoreboard bench for j11bus_target: directed cases then randomized transactions
// with behavioural memory/device responders.
module tb_j11bus_target;
  localparam logic [21:0] MT = 22'o01000000;
  localparam logic [21:0] IB = 22'o17760000;
  localparam int          TO = 8;
  localparam int          NEVER = 100;

  logic clk = 0, rst = 1;
  logic busreq = 0, buswr = 0, busgp = 0, busirq = 0;
  logic [21:0] busaddr = 0;
  logic [15:0] buswdata = 0;
  logic [1:0]  buswstrb = 0, busbs = 0;
  logic busack, buserr, mem_req, mem_wr, dev_req, dev_wr, irq_take, protoerr;
  logic [15:0] busrdata, mem_wdata, dev_wdata;
  logic [20:0] mem_addr;
  logic [12:0] dev_addr;
  logic [1:0]  mem_wstrb, dev_wstrb, dev_bs;
  logic mem_ack = 0, dev_ack = 0, dev_err = 0, irq_vld = 0;
  logic [15:0] mem_rdata = 0, dev_rdata = 0;
  logic [8:0]  irq_vec = 0;

  j11bus_target #(.MEMTOP(MT), .IOBASE(IB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .busreq(busreq), .buswr(buswr), .busgp(busgp), .busirq(busirq),
    .busaddr(busaddr), .buswdata(buswdata), .buswstrb(buswstrb), .busbs(busbs),
    .busack(busack), .busrdata(busrdata), .buserr(buserr),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dev_req(dev_req), .dev_wr(dev_wr), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_wstrb(dev_wstrb), .dev_bs(dev_bs), .dev_ack(dev_ack), .dev_err(dev_err),
    .dev_rdata(dev_rdata), .irq_vec(irq_vec), .irq_vld(irq_vld), .irq_take(irq_take),
    .protoerr(protoerr));

  always #5 clk = ~clk;

  typedef struct {
    logic wr, gp, irq, deverr, ivld;
    logic [21:0] addr;
    logic [15:0] wdata, rdata;
    logic [1:0]  strb, bs;
    logic [8:0]  ivec;
    int          wt;
  } txn_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err, take;
    int          lat, t0;
  } exp_t;

  exp_t sb[$];
  txn_t cur;
  int   cyc = 0, ncmp = 0, nfail = 0;
  bit   skip_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit is_mem(input txn_t t);
    return !t.irq && !t.gp && t.addr < MT;
  endfunction
  function automatic bit is_dev(input txn_t t);
    return !t.irq && !t.gp && t.addr >= IB;
  endfunction

  // Reference: what the initiator should see for a transaction, from the bus rules.
  function automatic exp_t ref_model(input txn_t t, input int t0);
    exp_t e;
    bit   tmo;
    e.t0 = t0; e.take = 0; e.err = 0; e.rdata = 0; e.lat = 2;
    if (t.irq) begin
      e.rdata = 16'(t.ivec); e.err = !t.ivld; e.take = t.ivld;
    end else if (t.gp) begin
      e.err = 0;
    end else if (is_mem(t) || is_dev(t)) begin
      tmo   = t.wt >= TO;
      e.lat = tmo ? TO + 2 : t.wt + 3;
      e.err = tmo ? 1'b1 : (is_dev(t) ? t.deverr : 1'b0);
      e.rdata = (tmo || t.wr) ? 16'h0 : t.rdata;
    end else begin
      e.err = 1;
    end
    return e;
  endfunction

  task automatic issue(input txn_t t);
    cur = t;
    irq_vld = t.ivld; irq_vec = t.ivec;
    busreq = 1; buswr = t.wr; busgp = t.gp; busirq = t.irq; busaddr = t.addr;
    buswdata = t.wdata; buswstrb = t.strb; busbs = t.bs;
    sb.push_back(ref_model(t, cyc));
    @(negedge clk);
    busreq = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("ack_wait_bound", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic txn_t mk(input logic wr, gp, irq, input logic [21:0] a, input int wt);
    txn_t t;
    t.wr = wr; t.gp = gp; t.irq = irq; t.addr = a; t.wt = wt;
    t.wdata = 16'($urandom); t.rdata = 16'($urandom); t.strb = 2'($urandom_range(1, 3));
    t.bs = 2'($urandom); t.ivec = 9'($urandom); t.ivld = 1'($urandom); t.deverr = 1'($urandom);
    return t;
  endfunction

  // Monitor: one expected entry per busack; flags never asserted off the ack cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (busack) begin
        chk("ack_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("busrdata", busrdata, e.rdata);
          chk("buserr", buserr, e.err);
          chk("irq_take", irq_take, e.take);
          chk("latency", cyc - e.t0, e.lat);
        end
      end else begin
        chk("stray_flags", {irq_take, buserr}, 0);
      end
    end
  end

  // Memory responder: acks after cur.wt cycles of mem_req, checks request fields.
  always @(negedge clk) begin : mem_rsp
    int cnt;
    if (mem_req && !rst) begin
      if (cnt == 0) begin
        chk("mem_region", 32'(is_mem(cur)), 1);
        chk("mem_addr", mem_addr, cur.addr[21:1]);
        chk("mem_wr", mem_wr, cur.wr);
        chk("mem_wstrb", mem_wstrb, cur.wr ? cur.strb : 2'b11);
        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      mem_ack = (cnt == cur.wt);
      mem_rdata = mem_ack ? cur.rdata : 16'hxxxx;
      cnt++;
    end else begin
      if (cnt > 0 && !skip_cyc) chk("mem_req_cycles", cnt, cur.wt >= TO ? TO : cur.wt + 1);
      mem_ack = 0; cnt = 0;
    end
  end

  always @(negedge clk) begin : dev_rsp
    int cnt;
    if (dev_req && !rst) begin
      if (cnt == 0) begin
        chk("dev_region", 32'(is_dev(cur)), 1);
        chk("dev_addr", dev_addr, cur.addr[12:0]);
        chk("dev_wr", dev_wr, cur.wr);
        chk("dev_wstrb", dev_wstrb, cur.wr ? cur.strb : 2'b11);
        chk("dev_bs", dev_bs, cur.bs);
        if (cur.wr) chk("dev_wdata", dev_wdata, cur.wdata);
      end
      dev_ack = (cnt == cur.wt);
      dev_err = dev_ack ? cur.deverr : 1'b0;
      dev_rdata = dev_ack ? cur.rdata : 16'hxxxx;
      cnt++;
    end else begin
      if (cnt > 0 && !skip_cyc) chk("dev_req_cycles", cnt, cur.wt >= TO ? TO : cur.wt + 1);
      dev_ack = 0; dev_err = 0; cnt = 0;
    end
  end

  initial begin
    txn_t t;
    int   k, n;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busack, buserr, mem_req, dev_req, irq_take, protoerr}, 0);
    chk("rst_busrdata", busrdata, 0);
    rst = 0;
    @(negedge clk);

    t = mk(0, 0, 0, 22'o001000, 3); t.rdata = 16'o123456; issue(t); wait_done();
    t = mk(1, 0, 0, 22'o17777560, 0); t.strb = 2'b10; t.wdata = 16'h4100; t.bs = 2'b01;
    t.deverr = 0; issue(t); wait_done();
    t = mk(0, 0, 0, 22'o17000000, 0); issue(t); wait_done();
    t = mk(0, 0, 0, 22'o17777700, NEVER); issue(t); wait_done();
    t = mk(0, 0, 0, 22'o000100, TO - 1); issue(t); wait_done();
    t = mk(0, 0, 1, 22'o0, 0); t.ivld = 1; t.ivec = 9'o060; issue(t); wait_done();
    t.ivld = 0; issue(t); wait_done();
    t = mk(1, 1, 0, 22'o000200, 0); issue(t); wait_done();
    t = mk(0, 1, 0, 22'o17777000, 0); issue(t); wait_done();

    // Reset while a memory request is outstanding drops the request silently.
    skip_cyc = 1;
    t = mk(0, 0, 0, 22'o002000, NEVER); issue(t);
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("mem_req_before_rst", mem_req, 1);
    @(negedge clk);
    rst = 1; sb.delete();
    @(negedge clk);
    rst = 0;
    chk("mem_req_after_rst", mem_req, 0);
    repeat (TO + 4) @(negedge clk);
    skip_cyc = 0;
    chk("protoerr_clear", protoerr, 0);

    // A second strobe during a memory cycle is ignored but flagged.
    t = mk(0, 0, 0, 22'o004000, 5); issue(t);
    @(negedge clk); @(negedge clk);
    busreq = 1; busaddr = 22'o17777560;
    @(negedge clk);
    busreq = 0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("protoerr_set", protoerr, 1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      n = ($urandom_range(0, 9) == 9) ? NEVER : $urandom_range(0, TO - 1);
      case (k)
        0: t = mk(0, 0, 1, 22'($urandom), 0);
        1: t = mk(1'($urandom), 1, 0, 22'($urandom), 0);
        2: t = mk(1'($urandom), 0, 0, MT + 22'($urandom_range(0, int'(IB - MT) - 1)), 0);
        3, 4, 5, 6: t = mk(1'($urandom), 0, 0, 22'($urandom_range(0, int'(MT) - 1)), n);
        default: t = mk(1'($urandom), 0, 0, IB + 22'($urandom_range(0, (1 << 22) - int'(IB) - 1)), n);
      endcase
      issue(t);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
